// File: rtl/capture_dump_ctrl.sv
// Trace dump sequencer: reads one channel's circular trace RAM oldest-first and
// hands each byte to a transmitter, handshaking on tx_done.
module capture_dump_ctrl #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dump_req,
    input  logic [1:0]    dump_chan,
    input  logic          cap_done,
    input  logic [AW-1:0] trace_end,
    input  logic [7:0]    ram_rdata,
    input  logic          tx_done,
    output logic          ram_en,
    output logic [AW-1:0] ram_addr,
    output logic [1:0]    chan_sel,
    output logic [7:0]    tx_data,
    output logic          trmt,
    output logic          dump_busy,
    output logic          clr_cap_done,
    output logic          dump_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_SEND,
        S_TXWAIT,
        S_FINISH
    } state_t;

    localparam logic [10:0]   DEPTH_W = 11'(DEPTH);
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [1:0]    chan_q,  chan_d;
    logic [7:0]    data_q,  data_d;
    logic [9:0]    sent_q,  sent_d;
    logic          err_q,   err_d;
    logic [9:0]    sent_inc;

    assign sent_inc = sent_q + 10'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            chan_q  <= '0;
            data_q  <= '0;
            sent_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            chan_q  <= chan_d;
            data_q  <= data_d;
            sent_q  <= sent_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        chan_d  = chan_q;
        data_d  = data_q;
        sent_d  = sent_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dump_req) begin
                    if (cap_done && (dump_chan != 2'd3)) begin
                        // Oldest sample sits just past the last written address.
                        state_d = S_READ;
                        chan_d  = dump_chan;
                        addr_d  = trace_end + ADDR_ONE;
                        sent_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_READ:   state_d = S_LATCH;
            S_LATCH: begin
                data_d  = ram_rdata;
                state_d = S_SEND;
            end
            S_SEND:   state_d = S_TXWAIT;
            S_TXWAIT: begin
                if (tx_done) begin
                    addr_d  = addr_q + ADDR_ONE;
                    sent_d  = sent_inc;
                    state_d = ({1'b0, sent_inc} < DEPTH_W) ? S_READ : S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ram_en       = 1'b0;
        trmt         = 1'b0;
        clr_cap_done = 1'b0;
        dump_busy    = (state_q != S_IDLE);
        case (state_q)
            S_READ:   ram_en       = 1'b1;
            S_SEND:   trmt         = 1'b1;
            S_FINISH: clr_cap_done = 1'b1;
            default:  ;
        endcase
    end

    assign ram_addr = addr_q;
    assign chan_sel = chan_q;
    assign tx_data  = data_q;
    assign dump_err = err_q;

endmodule

// File: tb/tb_capture_dump_ctrl.sv
// Directed bench for capture_dump_ctrl: RAM model returns addr[7:0], transmitter
// model answers each trmt with tx_done about 10 cycles later.
module tb_capture_dump_ctrl;

    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          dump_req  = 1'b0;
    logic [1:0]    dump_chan = 2'd0;
    logic          cap_done  = 1'b0;
    logic [AW-1:0] trace_end = '0;
    logic [7:0]    ram_rdata = 8'd0;
    logic          tx_done;
    logic          tx_auto   = 1'b0;
    logic          tx_spur   = 1'b0;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [1:0]    chan_sel;
    logic [7:0]    tx_data;
    logic          trmt;
    logic          dump_busy;
    logic          clr_cap_done;
    logic          dump_err;

    assign tx_done = tx_auto | tx_spur;

    capture_dump_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .dump_req     (dump_req),
        .dump_chan    (dump_chan),
        .cap_done     (cap_done),
        .trace_end    (trace_end),
        .ram_rdata    (ram_rdata),
        .tx_done      (tx_done),
        .ram_en       (ram_en),
        .ram_addr     (ram_addr),
        .chan_sel     (chan_sel),
        .tx_data      (tx_data),
        .trmt         (trmt),
        .dump_busy    (dump_busy),
        .clr_cap_done (clr_cap_done),
        .dump_err     (dump_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) ram_rdata <= ram_addr[7:0];
    end

    int vectors = 0;
    int miscompares = 0;

    logic [AW-1:0] addr_log[$];
    logic [7:0]    byte_log[$];
    int clr_cnt = 0, err_cnt = 0, txd_cnt = 0, chan_bad = 0;
    int timing_err = 0, stable_err = 0, busy_cycles = 0, resp_cnt = 0;
    logic [1:0] exp_chan = 2'd0;
    logic [7:0] last_byte = 8'd0;
    logic en_d1 = 1'b0, en_d2 = 1'b0;

    // Monitor plus transmitter model, both evaluated on the falling edge.
    always @(negedge clk) begin
        if (tx_auto) begin
            txd_cnt++;
            if (tx_data !== last_byte) stable_err++;
        end
        if (ram_en) addr_log.push_back(ram_addr);
        if (trmt) begin
            byte_log.push_back(tx_data);
            last_byte = tx_data;
            if (!(en_d2 && !en_d1)) timing_err++;
        end
        en_d2 = en_d1;
        en_d1 = ram_en;
        if (clr_cap_done) clr_cnt++;
        if (dump_err) err_cnt++;
        if (dump_busy) begin
            busy_cycles++;
            if (chan_sel !== exp_chan) chan_bad++;
        end
        tx_auto = 1'b0;
        if (rst) begin
            resp_cnt = 0;
        end else begin
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) tx_auto = 1'b1;
            end
            if (trmt) resp_cnt = 10;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_dump(input logic [AW-1:0] te, input logic [1:0] ch);
        trace_end = te;
        dump_chan = ch;
        exp_chan  = ch;
        dump_req  = 1'b1;
        step();
        dump_req  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (dump_busy && n < 10000) begin
            step();
            n++;
        end
        vectors++;
        if (dump_busy) begin
            miscompares++;
            $display("FAIL %s_timeout: dump_busy=%0b after %0d cycles, required 0", name, dump_busy, n);
        end
    endtask

    // Counts bytes/addresses logged since the given bases and how many deviate
    // from the expected oldest-first sequence starting at 'start'.
    task automatic analyze(input int ab, input int bb, input logic [AW-1:0] start,
                           output int na, output int nb, output int bad);
        logic [AW-1:0] e;
        na  = addr_log.size() - ab;
        nb  = byte_log.size() - bb;
        bad = 0;
        for (int i = 0; i < nb && i < DEPTH; i++) begin
            e = start + AW'(i);
            if (byte_log[bb+i] !== e[7:0]) bad++;
        end
        for (int i = 0; i < na && i < DEPTH; i++) begin
            e = start + AW'(i);
            if (addr_log[ab+i] !== e) bad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        vectors++;
        if ({ram_en, ram_addr, chan_sel, tx_data, trmt, dump_busy, clr_cap_done, dump_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: en=%0b addr=%h chan=%0d data=%h trmt=%0b busy=%0b clr=%0b err=%0b, required all 0",
                     ram_en, ram_addr, chan_sel, tx_data, trmt, dump_busy, clr_cap_done, dump_err);
        end
        rst = 1'b0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int ab, bb, c0, e0, ch0, t0, s0, na, nb, bad;
        ab = addr_log.size(); bb = byte_log.size();
        c0 = clr_cnt; e0 = err_cnt; ch0 = chan_bad; t0 = timing_err; s0 = stable_err;
        cap_done = 1'b1;
        start_dump(9'h0FF, 2'd1);
        vectors++;
        if ({dump_busy, ram_en, ram_addr, chan_sel} !== {1'b1, 1'b1, 9'h100, 2'd1}) begin
            miscompares++;
            $display("FAIL basic_first_read: busy=%0b en=%0b addr=%h chan=%0d, required 1 1 100 1",
                     dump_busy, ram_en, ram_addr, chan_sel);
        end
        step();
        vectors++;
        if ({ram_en, trmt} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_latch: en=%0b trmt=%0b, required 0 0", ram_en, trmt);
        end
        step();
        vectors++;
        if ({trmt, tx_data} !== {1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL basic_first_send: trmt=%0b data=%h, required 1 00", trmt, tx_data);
        end
        wait_idle("basic");
        analyze(ab, bb, 9'h100, na, nb, bad);
        vectors++;
        if (nb != DEPTH || na != DEPTH) begin
            miscompares++;
            $display("FAIL basic_count: bytes=%0d reads=%0d, required %0d", nb, na, DEPTH);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL basic_sequence: %0d wrong bytes/addresses, required 0", bad);
        end
        vectors++;
        if (clr_cnt - c0 != 1 || err_cnt - e0 != 0) begin
            miscompares++;
            $display("FAIL basic_pulses: clr=%0d err=%0d, required 1 0", clr_cnt - c0, err_cnt - e0);
        end
        vectors++;
        if (chan_bad - ch0 != 0 || timing_err - t0 != 0 || stable_err - s0 != 0) begin
            miscompares++;
            $display("FAIL basic_protocol: chan_bad=%0d timing=%0d unstable=%0d, required 0 0 0",
                     chan_bad - ch0, timing_err - t0, stable_err - s0);
        end
        cap_done = 1'b0;
        $display("test_basic done: %0d bytes", nb);
    endtask

    task automatic test_wrap();
        int ab, bb, c0, na, nb, bad;
        ab = addr_log.size(); bb = byte_log.size(); c0 = clr_cnt;
        cap_done = 1'b1;
        start_dump(9'h1FF, 2'd2);
        vectors++;
        if (ram_addr !== 9'h000) begin
            miscompares++;
            $display("FAIL wrap_first_addr: addr=%h, required 000", ram_addr);
        end
        wait_idle("wrap");
        analyze(ab, bb, 9'h000, na, nb, bad);
        vectors++;
        if (na != DEPTH || addr_log[addr_log.size()-1] !== 9'h1FF) begin
            miscompares++;
            $display("FAIL wrap_last_addr: reads=%0d last=%h, required %0d 1ff",
                     na, addr_log[addr_log.size()-1], DEPTH);
        end
        vectors++;
        if (nb != DEPTH || bad != 0 || clr_cnt - c0 != 1) begin
            miscompares++;
            $display("FAIL wrap_dump: bytes=%0d bad=%0d clr=%0d, required %0d 0 1",
                     nb, bad, clr_cnt - c0, DEPTH);
        end
        cap_done = 1'b0;
        $display("test_wrap done: %0d bytes", nb);
    endtask

    task automatic test_reject();
        int ab, bb, e0, b0;
        ab = addr_log.size(); bb = byte_log.size(); e0 = err_cnt; b0 = busy_cycles;
        for (int k = 0; k < 2; k++) begin
            cap_done  = (k == 1);
            dump_chan = (k == 1) ? 2'd3 : 2'd0;
            trace_end = 9'h055;
            dump_req  = 1'b1;
            step();
            dump_req  = 1'b0;
            vectors++;
            if ({dump_err, dump_busy, ram_en} !== 3'b100) begin
                miscompares++;
                $display("FAIL reject%0d_pulse: err=%0b busy=%0b en=%0b, required 1 0 0",
                         k, dump_err, dump_busy, ram_en);
            end
            step();
            vectors++;
            if (dump_err !== 1'b0) begin
                miscompares++;
                $display("FAIL reject%0d_width: err=%0b, required 0", k, dump_err);
            end
        end
        repeat (5) step();
        vectors++;
        if (err_cnt - e0 != 2 || addr_log.size() != ab || byte_log.size() != bb || busy_cycles != b0) begin
            miscompares++;
            $display("FAIL reject_quiet: errs=%0d reads=%0d sends=%0d busy=%0d, required 2 0 0 0",
                     err_cnt - e0, addr_log.size() - ab, byte_log.size() - bb, busy_cycles - b0);
        end
        cap_done = 1'b0;
        dump_chan = 2'd0;
        $display("test_reject done");
    endtask

    task automatic test_back_to_back();
        int ab, bb, c0, e0, ch0, t0, na, nb, bad, k, inj;
        logic prev_en;
        ab = addr_log.size(); bb = byte_log.size();
        c0 = clr_cnt; e0 = err_cnt; ch0 = chan_bad; t0 = timing_err;
        cap_done = 1'b1;
        start_dump(9'h07F, 2'd0);
        trace_end = 9'h0AA;
        k = 0; inj = 0; prev_en = 1'b0;
        while (dump_busy && k < 10000) begin
            tx_spur  = 1'b0;
            dump_req = 1'b0;
            if (ram_en && (k % 3 == 0)) begin
                tx_spur  = 1'b1;
                dump_req = 1'b1;
                inj++;
            end
            if (prev_en && (k % 5 == 0)) begin
                tx_spur   = 1'b1;
                dump_req  = 1'b1;
                dump_chan = (k % 2 == 0) ? 2'd3 : 2'd2;
                inj++;
            end
            if (byte_log.size() - bb == 50) cap_done = 1'b0;
            prev_en = ram_en;
            step();
            k++;
        end
        tx_spur  = 1'b0;
        dump_req = 1'b0;
        wait_idle("b2b");
        analyze(ab, bb, 9'h080, na, nb, bad);
        vectors++;
        if (nb != DEPTH || na != DEPTH || bad != 0) begin
            miscompares++;
            $display("FAIL b2b_sequence: bytes=%0d reads=%0d bad=%0d, required %0d %0d 0",
                     nb, na, bad, DEPTH, DEPTH);
        end
        vectors++;
        if (clr_cnt - c0 != 1 || err_cnt - e0 != 0 || chan_bad - ch0 != 0 || timing_err - t0 != 0) begin
            miscompares++;
            $display("FAIL b2b_pulses: clr=%0d err=%0d chan_bad=%0d timing=%0d, required 1 0 0 0",
                     clr_cnt - c0, err_cnt - e0, chan_bad - ch0, timing_err - t0);
        end
        cap_done = 1'b0;
        $display("test_back_to_back done: %0d injections", inj);
    endtask

    task automatic test_reset_mid();
        int bb, tb0, c0, b_at, ab, na, nb, bad, n;
        bb = byte_log.size(); tb0 = txd_cnt;
        cap_done = 1'b1;
        start_dump(9'h010, 2'd2);
        n = 0;
        while (txd_cnt - tb0 < 100 && n < 5000) begin
            step();
            n++;
        end
        vectors++;
        if (txd_cnt - tb0 < 100) begin
            miscompares++;
            $display("FAIL rstmid_progress: tx_done=%0d, required 100", txd_cnt - tb0);
        end
        rst = 1'b1;
        c0 = clr_cnt;
        b_at = byte_log.size();
        step();
        vectors++;
        if ({ram_en, ram_addr, chan_sel, tx_data, trmt, dump_busy, clr_cap_done, dump_err} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: en=%0b addr=%h chan=%0d data=%h trmt=%0b busy=%0b clr=%0b err=%0b, required all 0",
                     ram_en, ram_addr, chan_sel, tx_data, trmt, dump_busy, clr_cap_done, dump_err);
        end
        rst = 1'b0;
        repeat (20) step();
        vectors++;
        if (b_at - bb != 100 || byte_log.size() != b_at || clr_cnt != c0) begin
            miscompares++;
            $display("FAIL rstmid_abort: sent_before=%0d sent_after=%0d clr=%0d, required 100 0 0",
                     b_at - bb, byte_log.size() - b_at, clr_cnt - c0);
        end
        ab = addr_log.size(); bb = byte_log.size(); c0 = clr_cnt;
        start_dump(9'h155, 2'd1);
        vectors++;
        if (ram_addr !== 9'h156) begin
            miscompares++;
            $display("FAIL rstmid_restart_addr: addr=%h, required 156", ram_addr);
        end
        wait_idle("rstmid");
        analyze(ab, bb, 9'h156, na, nb, bad);
        vectors++;
        if (nb != DEPTH || na != DEPTH || bad != 0 || clr_cnt - c0 != 1) begin
            miscompares++;
            $display("FAIL rstmid_redump: bytes=%0d reads=%0d bad=%0d clr=%0d, required %0d %0d 0 1",
                     nb, na, bad, clr_cnt - c0, DEPTH, DEPTH);
        end
        cap_done = 1'b0;
        $display("test_reset_mid done: %0d bytes after restart", nb);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_reject();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/capture_dump_ctrl.md
CAPTURE_DUMP_CTRL -- requirements
Module: capture_dump_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 512: number of entries per channel trace RAM.
REQ-002 SHALL have parameter AW, default 9: RAM address width (2^AW == DEPTH).
REQ-003 SHALL have clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have dump_req  input  1  one-cycle pulse requesting a trace dump.
REQ-006 SHALL have dump_chan  input  2  channel to dump, 0..2; 3 is invalid.
REQ-007 SHALL have cap_done  input  1  capture-complete flag from the capture block.
REQ-008 SHALL have trace_end  input  AW  address of the last sample written.
REQ-009 SHALL have ram_rdata  input  8  RAM read data, valid one cycle after ram_en.
REQ-010 SHALL have tx_done  input  1  one-cycle pulse from the transmitter, byte sent.
REQ-011 SHALL have ram_en  output  1  RAM read enable.
REQ-012 SHALL have ram_addr  output  AW  RAM read address.
REQ-013 SHALL have chan_sel  output  2  RAM bank select, held for the whole dump.
REQ-014 SHALL have tx_data  output  8  byte to transmit.
REQ-015 SHALL have trmt  output  1  one-cycle transmit strobe.
REQ-016 SHALL have dump_busy  output  1  high from dump acceptance until FINISH exits.
REQ-017 SHALL have clr_cap_done  output  1  one-cycle pulse; clears cap_done upstream.
REQ-018 SHALL have dump_err  output  1  one-cycle pulse on a rejected request.

Function
REQ-019 SHALL implement the states IDLE, READ, LATCH, SEND, TXWAIT and FINISH.
REQ-020 SHALL, in IDLE, accept a dump only when dump_req=1, cap_done=1 and dump_chan!=3.
REQ-021 SHALL, on acceptance:
- latch dump_chan into chan_sel;
- load start address = (trace_end+1) mod DEPTH;
- clear a 10-bit sent counter;
- go to READ.
REQ-022 SHALL, on dump_req in IDLE with cap_done=0 or dump_chan=3, pulse dump_err next cycle and stay in IDLE.
REQ-023 SHALL, in READ, assert ram_en=1 for exactly one cycle with ram_addr = the current address, then go to LATCH.
REQ-024 SHALL, in LATCH, register ram_rdata into tx_data, then go to SEND.
REQ-025 SHALL, in SEND, pulse trmt for one cycle, then go to TXWAIT; tx_data SHALL hold stable until tx_done.
REQ-026 SHALL, in TXWAIT on tx_done:
- increment the address modulo DEPTH (natural AW-bit wrap, 511->0);
- increment the sent counter;
- go to READ if sent < DEPTH, else go to FINISH.
REQ-027 SHALL, in FINISH, pulse clr_cap_done for one cycle, then return to IDLE.
REQ-028 SHALL transmit exactly DEPTH bytes per dump, oldest sample first; trace_end's byte is last.
REQ-029 SHALL ignore dump_req while dump_busy=1, with no dump_err and no restart.
REQ-030 SHALL ignore tx_done outside TXWAIT.
REQ-031 SHALL sample trace_end only at acceptance; later changes do not affect the dump in progress.
REQ-032 SHALL continue a dump in progress if cap_done falls mid-dump; clr_cap_done is still pulsed in FINISH.
REQ-033 SHALL cause, per byte, at least 3 cycles plus transmitter time, with trmt occurring 2 cycles after ram_en.
REQ-034 SHALL drive ram_en=0 in every state except READ.

Reset
REQ-035 SHALL, on rst=1 at a clock edge, enter IDLE and set all of the following to 0:
- ram_en, trmt, dump_busy, clr_cap_done, dump_err;
- ram_addr, chan_sel, tx_data;
- the sent counter.
REQ-036 SHALL, on rst mid-dump, abort immediately with no further trmt and no clr_cap_done pulse.

Verification
REQ-037 SHALL cover this scenario:
- stimulus: cap_done=1, trace_end=0x0FF, dump_chan=1, dump_req, RAM model data = addr[7:0], tx_done 10 cycles after each trmt;
- response: 512 trmt pulses carrying bytes 0x00..0xFF twice (addresses 0x100..0x1FF then 0x000..0x0FF), chan_sel=1 throughout, one clr_cap_done pulse, dump_busy then low.
REQ-038 SHALL cover this scenario:
- stimulus: trace_end=0x1FF;
- response: first ram_addr=0x000, last ram_addr=0x1FF.
REQ-039 SHALL cover this scenario:
- stimulus: dump_req with cap_done=0, and separately dump_req with dump_chan=3;
- response: one dump_err pulse each, ram_en and trmt stay 0, dump_busy stays 0.
REQ-040 SHALL cover this scenario:
- stimulus: dump_req pulses and spurious tx_done pulses injected during READ or LATCH mid-dump;
- response: byte count still exactly 512 and address sequence unchanged.
REQ-041 SHALL cover this scenario:
- stimulus: rst asserted after the 100th tx_done, then a new dump_req;
- response: all outputs 0 the cycle after reset, no clr_cap_done pulse, and a fresh 512-byte dump from the newly sampled trace_end.
